// File: rtl/dhcp_manager.sv
// dhcp_manager: supervises an external DHCP engine. It starts discovery on
// link-up, retries with growing back-off, tracks the lease once bound,
// issues a renewal at half-lease and restarts discovery at expiry.
// Optional feature: define DHCP_FALLBACK_IP_EN to assign a 169.254.x.y
// link-local address once retries are exhausted.
module dhcp_manager #(
    parameter int unsigned CLK_HZ    = 125000000,
    parameter int unsigned TIMEOUT_S = 4,
    parameter int unsigned MAX_RETRY = 5
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        link_up,
    input  logic        dhcp_success,
    input  logic        dhcp_failed,
    input  logic [31:0] ip_accept,
    input  logic [31:0] lease,
    input  logic [47:0] local_mac,
    output logic        dhcp_start,
    output logic        ip_valid,
    output logic [31:0] assigned_ip,
    output logic [31:0] lease_remaining,
    output logic        dhcp_gave_up,
    output logic [2:0]  mgr_state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DISCOVER = 3'd1,
        ST_WAIT     = 3'd2,
        ST_BOUND    = 3'd3,
        ST_BACKOFF  = 3'd4,
        ST_FAILED   = 3'd5
    } state_t;

    localparam int unsigned   PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [31:0]   INFINITE   = 32'hFFFF_FFFF;
    localparam logic [31:0]   TIMEOUT_LAST = 32'(TIMEOUT_S) - 32'd1;
    localparam logic [31:0]   RETRY_LIMIT  = 32'(MAX_RETRY);

    state_t        state;
    logic [PW-1:0] presc;
    logic          tick;
    logic [31:0]   sec_cnt;
    logic [31:0]   retry_cnt;
    logic [31:0]   lease_full;
    logic          renew_issued;
    logic          success_prev;
    logic          failed_prev;
    logic          success_rise;
    logic          failed_rise;

    // A lease of 0 or 1 s would expire before renewal could happen; treat it as 2 s.
    function automatic logic [31:0] load_lease(input logic [31:0] l);
        return (l < 32'd2) ? 32'd2 : l;
    endfunction

    assign tick         = (presc == PRESC_LAST);
    assign success_rise = dhcp_success & ~success_prev;
    assign failed_rise  = dhcp_failed & ~failed_prev;
    assign mgr_state    = state;

`ifdef DHCP_FALLBACK_IP_EN
    // Upper MAC bits play no part in the link-local address.
    logic unused_mac;
    assign unused_mac = ^local_mac[47:16];
`else
    // Without the fallback address the MAC is not needed at all.
    logic unused_mac;
    assign unused_mac = ^local_mac;
`endif

    // Previous values of the engine's status levels, for rising-edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            success_prev <= 1'b0;
            failed_prev  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from
            // the same pre-edge values, so ordering inside the block is irrelevant.
            success_prev <= dhcp_success;
            failed_prev  <= dhcp_failed;
        end
    end

    // Manager FSM together with the one-second prescaler, counters and outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            presc           <= '0;
            sec_cnt         <= '0;
            retry_cnt       <= '0;
            lease_full      <= '0;
            renew_issued    <= 1'b0;
            dhcp_start      <= 1'b0;
            ip_valid        <= 1'b0;
            assigned_ip     <= '0;
            lease_remaining <= '0;
            dhcp_gave_up    <= 1'b0;
        end else begin
            dhcp_start <= 1'b0;
            presc      <= tick ? '0 : presc + PW'(1);

            if (!link_up) begin
                state           <= ST_IDLE;
                ip_valid        <= 1'b0;
                assigned_ip     <= '0;
                lease_remaining <= '0;
                dhcp_gave_up    <= 1'b0;
                renew_issued    <= 1'b0;
                retry_cnt       <= '0;
                sec_cnt         <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state     <= ST_DISCOVER;
                        retry_cnt <= '0;
                    end

                    ST_DISCOVER: begin
                        dhcp_start <= 1'b1;
                        state      <= ST_WAIT;
                        sec_cnt    <= '0;
                        presc      <= '0;
                    end

                    ST_WAIT: begin
                        // Success outranks a simultaneous failure report.
                        if (success_rise) begin
                            state           <= ST_BOUND;
                            assigned_ip     <= ip_accept;
                            lease_full      <= load_lease(lease);
                            lease_remaining <= load_lease(lease);
                            ip_valid        <= 1'b1;
                            retry_cnt       <= '0;
                            renew_issued    <= 1'b0;
                        end else if (failed_rise || (tick && sec_cnt == TIMEOUT_LAST)) begin
                            retry_cnt <= retry_cnt + 32'd1;
                            sec_cnt   <= '0;
                            if (retry_cnt + 32'd1 == RETRY_LIMIT) begin
                                state        <= ST_FAILED;
                                dhcp_gave_up <= 1'b1;
`ifdef DHCP_FALLBACK_IP_EN
                                assigned_ip     <= {8'd169, 8'd254, local_mac[15:8], local_mac[7:0]};
                                ip_valid        <= 1'b1;
                                lease_remaining <= '0;
`else
                                assigned_ip <= '0;
                                ip_valid    <= 1'b0;
`endif
                            end else begin
                                state <= ST_BACKOFF;
                                presc <= '0;
                            end
                        end else if (tick) begin
                            sec_cnt <= sec_cnt + 32'd1;
                        end
                    end

                    ST_BACKOFF: begin
                        // Back-off length in seconds equals the number of failed attempts.
                        if (tick) begin
                            if (sec_cnt + 32'd1 == retry_cnt) begin
                                state   <= ST_DISCOVER;
                                sec_cnt <= '0;
                            end else begin
                                sec_cnt <= sec_cnt + 32'd1;
                            end
                        end
                    end

                    ST_BOUND: begin
                        if (success_rise) begin
                            assigned_ip     <= ip_accept;
                            lease_full      <= load_lease(lease);
                            lease_remaining <= load_lease(lease);
                            renew_issued    <= 1'b0;
                        end else if (lease_full != INFINITE) begin
                            if (tick && lease_remaining <= 32'd1) begin
                                state           <= ST_DISCOVER;
                                lease_remaining <= '0;
                                ip_valid        <= 1'b0;
                                assigned_ip     <= '0;
                                retry_cnt       <= '0;
                                renew_issued    <= 1'b0;
                            end else begin
                                if (tick) begin
                                    lease_remaining <= lease_remaining - 32'd1;
                                end
                                if (!renew_issued && lease_remaining == (lease_full >> 1)) begin
                                    dhcp_start   <= 1'b1;
                                    renew_issued <= 1'b1;
                                end
                            end
                        end
                    end

                    ST_FAILED: begin
                        dhcp_gave_up <= 1'b1;
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dhcp_manager.sv
// Self-checking bench for dhcp_manager with CLK_HZ=10, TIMEOUT_S=4,
// MAX_RETRY=5. Expected timing is derived arithmetically from the
// prescaler phase (cleared when WAIT starts) and the protocol rules.
module tb_dhcp_manager;

    localparam int C = 10;
    localparam int T = 4;
    localparam int R = 5;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        link_up = 1'b0;
    logic        dhcp_success = 1'b0;
    logic        dhcp_failed = 1'b0;
    logic [31:0] ip_accept = '0;
    logic [31:0] lease = '0;
    logic [47:0] local_mac = 48'h02_00_00_00_12_34;
    logic        dhcp_start;
    logic        ip_valid;
    logic [31:0] assigned_ip;
    logic [31:0] lease_remaining;
    logic        dhcp_gave_up;
    logic [2:0]  mgr_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses = 0;
    int last_pulse = -1;
    int w = 0;

    dhcp_manager #(.CLK_HZ(C), .TIMEOUT_S(T), .MAX_RETRY(R)) dut (
        .clock(clock), .reset_n(reset_n), .link_up(link_up),
        .dhcp_success(dhcp_success), .dhcp_failed(dhcp_failed),
        .ip_accept(ip_accept), .lease(lease), .local_mac(local_mac),
        .dhcp_start(dhcp_start), .ip_valid(ip_valid), .assigned_ip(assigned_ip),
        .lease_remaining(lease_remaining), .dhcp_gave_up(dhcp_gave_up),
        .mgr_state(mgr_state)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (dhcp_start === 1'b1) begin
            pulses++;
            last_pulse = cyc;
        end
    endtask

    // Ticks occur in cycles w+k*C-1 (k>=1); count those within [w, x].
    function automatic int ticks_upto(input int x);
        if (x < w) return 0;
        return (x - w + 1) / C;
    endfunction

    function automatic int ticks_in(input int a, input int b);
        return ticks_upto(b) - ticks_upto(a - 1);
    endfunction

    function automatic logic [31:0] eff_lease(input logic [31:0] l);
        return (l < 32'd2) ? 32'd2 : l;
    endfunction

    task automatic bring_up();
        link_up = 1'b1;
        step();
        check("discover_state", mgr_state, 3'd1);
        check("no_early_start", dhcp_start, 1'b0);
        step();
        check("start_pulse", dhcp_start, 1'b1);
        check("wait_state", mgr_state, 3'd2);
        w = cyc;
    endtask

    task automatic answer(input logic [31:0] ip, input logic [31:0] l, output int b);
        ip_accept = ip;
        lease = l;
        dhcp_success = 1'b1;
        step();
        b = cyc;
        dhcp_success = 1'b0;
        check("bound_state", mgr_state, 3'd3);
        check("bound_ip", assigned_ip, ip);
        check("bound_lease", lease_remaining, eff_lease(l));
        check("bound_valid", ip_valid, 1'b1);
    endtask

    task automatic drop_link();
        link_up = 1'b0;
        step();
        check("drop_state", mgr_state, 3'd0);
        check("drop_start", dhcp_start, 1'b0);
        check("drop_valid", ip_valid, 1'b0);
        check("drop_ip", assigned_ip, 32'd0);
        check("drop_lease", lease_remaining, 32'd0);
        check("drop_gave_up", dhcp_gave_up, 1'b0);
    endtask

    initial begin
        int b;
        int r;
        int p;
        int f_vis;
        logic [31:0] ip_r;
        logic [31:0] l_r;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_state", mgr_state, 3'd0);
        check("rst_start", dhcp_start, 1'b0);
        check("rst_valid", ip_valid, 1'b0);
        check("rst_ip", assigned_ip, 32'd0);
        check("rst_lease", lease_remaining, 32'd0);
        check("rst_gave_up", dhcp_gave_up, 1'b0);
        reset_n = 1'b1;
        step();
        check("idle_hold", mgr_state, 3'd0);

        // Acquire, half-lease renewal, reload
        bring_up();
        repeat ($urandom_range(1, 25)) step();
        check("wait_hold", mgr_state, 3'd2);
        answer(32'hC0A8_0164, 32'd100, b);
        pulses = 0;
        while (ticks_in(b, cyc - 1) < 50) step();
        check("lease_at_50", lease_remaining, 32'd50);
        check("no_pulse_before_half", pulses, 0);
        repeat (5) step();
        check("renew_once", pulses, 1);
        check("renew_valid", ip_valid, 1'b1);
        dhcp_failed = 1'b1;
        step();
        dhcp_failed = 1'b0;
        check("fail_ignored_bound", mgr_state, 3'd3);
        ip_r = $urandom();
        answer(ip_r, 32'd200, r);
        pulses = 0;
        while (ticks_in(r, cyc - 1) < 99) step();
        check("lease_at_101", lease_remaining, 32'd101);
        check("no_pulse_after_reload", pulses, 0);
        while (ticks_in(r, cyc - 1) < 100) step();
        check("lease_at_100", lease_remaining, 32'd100);
        repeat (3) step();
        check("second_renew", pulses, 1);
        drop_link();

        // Short leases to expiry: 3, then 0, 1 and random values
        bring_up();
        for (int i = 0; i < 5; i++) begin
            l_r = (i == 0) ? 32'd3 : (i < 3) ? 32'(i - 1) : 32'($urandom_range(2, 12));
            repeat ($urandom_range(1, 30)) step();
            answer($urandom(), l_r, b);
            pulses = 0;
            while (ticks_in(b, cyc - 1) < int'(eff_lease(l_r))) step();
            check("expiry_state", mgr_state, 3'd1);
            check("expiry_valid", ip_valid, 1'b0);
            check("expiry_ip", assigned_ip, 32'd0);
            check("expiry_renew_count", pulses, 1);
            step();
            check("expiry_restart", dhcp_start, 1'b1);
            check("expiry_wait", mgr_state, 3'd2);
            w = cyc;
        end
        repeat ($urandom_range(1, 30)) step();
        drop_link();

        // Simultaneous success/failure, lease 0, infinite lease
        bring_up();
        repeat ($urandom_range(1, 30)) step();
        ip_accept = $urandom();
        lease = 32'd0;
        dhcp_success = 1'b1;
        dhcp_failed = 1'b1;
        step();
        dhcp_success = 1'b0;
        dhcp_failed = 1'b0;
        check("both_rise_bound", mgr_state, 3'd3);
        check("both_rise_lease", lease_remaining, 32'd2);
        drop_link();
        bring_up();
        answer($urandom(), 32'hFFFF_FFFF, b);
        pulses = 0;
        repeat (6 * C) step();
        check("infinite_lease", lease_remaining, 32'hFFFF_FFFF);
        check("infinite_no_renew", pulses, 0);
        check("infinite_state", mgr_state, 3'd3);
        drop_link();

        // Failure report -> 1 s back-off -> rediscover
        bring_up();
        repeat ($urandom_range(1, 30)) step();
        dhcp_failed = 1'b1;
        step();
        dhcp_failed = 1'b0;
        check("backoff_after_fail", mgr_state, 3'd4);
        f_vis = cyc;
        pulses = 0;
        while (cyc < f_vis + C + 1) step();
        check("retry_pulse_count", pulses, 1);
        check("retry_pulse_time", last_pulse, f_vis + C + 1);
        drop_link();

        // No answers: five attempts, back-offs 1..4 s, then give up
        pulses = 0;
        bring_up();
        p = w;
        for (int k = 1; k < R; k++) begin
            while (cyc < p + T * C) step();
            check("timeout_backoff", mgr_state, 3'd4);
            while (cyc < p + T * C + k * C + 1) step();
            check("attempt_time", last_pulse, cyc);
            check("attempt_wait", mgr_state, 3'd2);
            p = cyc;
        end
        while (cyc < p + T * C) step();
        check("attempt_count", pulses, R);
        check("gave_up", dhcp_gave_up, 1'b1);
        check("failed_state", mgr_state, 3'd5);
`ifdef DHCP_FALLBACK_IP_EN
        check("fallback_ip", assigned_ip, 32'hA9FE_1234);
        check("fallback_valid", ip_valid, 1'b1);
`else
        check("failed_ip", assigned_ip, 32'd0);
        check("failed_valid", ip_valid, 1'b0);
`endif
        repeat (20) step();
        check("failed_sticky", mgr_state, 3'd5);
        check("failed_no_pulse", pulses, R);
        drop_link();

        // Asynchronous reset mid-operation
        bring_up();
        answer($urandom(), 32'd50, b);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_state", mgr_state, 3'd0);
        check("async_rst_valid", ip_valid, 1'b0);
        check("async_rst_lease", lease_remaining, 32'd0);
        #3;
        reset_n = 1'b1;
        step();
        check("resume_from_idle", mgr_state, 3'd1);
        drop_link();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dhcp_manager.md
DHCP_MANAGER -- requirements
Module: dhcp_manager

Interface
REQ-001 Parameter CLK_HZ, default 125000000, clock cycles per one-second tick.
REQ-002 Parameter TIMEOUT_S, default 4, seconds to wait for an answer per attempt.
REQ-003 Parameter MAX_RETRY, default 5, failed attempts before giving up.
REQ-004 clock  in  1  sole clock, all logic posedge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 link_up  in  1  PHY link level, already synchronised to clock.
REQ-007 dhcp_success  in  1  level from DHCP engine, already synchronised to clock.
REQ-008 dhcp_failed  in  1  level from DHCP engine, already synchronised to clock.
REQ-009 ip_accept  in  32  offered/acknowledged IP from DHCP engine.
REQ-010 lease  in  32  lease seconds from DHCP engine.
REQ-011 local_mac  in  48  station MAC.
REQ-012 dhcp_start  out  1  one-cycle pulse, drives DHCP engine tx_enable.
REQ-013 ip_valid  out  1  assigned_ip usable.
REQ-014 assigned_ip  out  32  current station IP.
REQ-015 lease_remaining  out  32  seconds left on current lease.
REQ-016 dhcp_gave_up  out  1  retries exhausted.
REQ-017 mgr_state  out  3  encoded state, for debug.

Function
REQ-018 States SHALL be IDLE=0, DISCOVER=1, WAIT=2, BOUND=3, BACKOFF=4, FAILED=5.
REQ-019 Tick: prescaler counts 0..CLK_HZ-1, one-cycle tick at terminal count; prescaler SHALL clear on every entry to WAIT or BACKOFF.
REQ-020 success_rise/failed_rise SHALL be rising-edge detects of the level inputs (one registered previous value each).
REQ-021 IDLE: link_up high -> DISCOVER, retry count cleared.
REQ-022 DISCOVER: dhcp_start high exactly one cycle, then WAIT with second counter cleared.
REQ-023 WAIT: success_rise -> BOUND, latch assigned_ip<=ip_accept, lease_remaining<=lease, ip_valid<=1, retry cleared.
REQ-024 WAIT: failed_rise, or second counter reaching TIMEOUT_S -> retry+1; if new retry==MAX_RETRY -> FAILED, else BACKOFF.
REQ-025 success_rise and failed_rise in same cycle: success wins.
REQ-026 BACKOFF: wait retry-count seconds (ticks), then DISCOVER.
REQ-027 BOUND: lease_remaining decrements by 1 per tick, saturating at 0; lease 32'hFFFFFFFF is infinite, never decrements, no renewal.
REQ-028 Lease value 0 or 1 SHALL be loaded as 2.
REQ-029 BOUND: when lease_remaining equals latched lease>>1 and renewal not yet issued -> one dhcp_start pulse, renew flag set, ip_valid stays 1.
REQ-030 BOUND: success_rise reloads assigned_ip, lease_remaining, clears renew flag; failed_rise ignored.
REQ-031 BOUND: lease_remaining reaching 0 -> ip_valid<=0, assigned_ip<=0, retry cleared, DISCOVER.
REQ-032 FAILED: dhcp_gave_up=1; stays until link_up drops.
REQ-033 link_up low in any state -> IDLE next cycle, ip_valid, assigned_ip, lease_remaining, dhcp_gave_up, renew flag cleared; no dhcp_start issued that cycle.
REQ-034 Outputs SHALL be registered; mgr_state reflects the current state register.

Reset
REQ-035 reset_n low: state IDLE; dhcp_start 0, ip_valid 0, assigned_ip 0, lease_remaining 0, dhcp_gave_up 0, prescaler, second and retry counters 0, edge-detect registers 0.
REQ-036 Reset asserted mid-operation SHALL abort immediately (asynchronous); deassertion resumes from IDLE.

Configuration
REQ-037 Macro DHCP_FALLBACK_IP_EN defined: on entry to FAILED, assigned_ip<={8'd169,8'd254,local_mac[15:8],local_mac[7:0]}, ip_valid<=1, lease_remaining 0; retry still latched as gave-up.
REQ-038 Macro undefined: FAILED keeps ip_valid 0, assigned_ip 0; no fallback logic synthesised.

Verification
REQ-039 CLK_HZ=10; link_up rises -> dhcp_start one pulse 2 cycles later; success_rise with ip_accept=C0A80164, lease=100 -> ip_valid=1, assigned_ip=C0A80164, lease_remaining=100.
REQ-040 Bound lease=100: after 50 ticks lease_remaining=50 and exactly one dhcp_start; new success lease=200 -> lease_remaining=200, no further pulse until 100.
REQ-041 No responses, TIMEOUT_S=4, MAX_RETRY=5: exactly 5 dhcp_start pulses, backoffs 1,2,3,4 s, then dhcp_gave_up=1, mgr_state=5.
REQ-042 Same with DHCP_FALLBACK_IP_EN, local_mac=...12:34 -> assigned_ip=A9FE1234, ip_valid=1.
REQ-043 Lease=3, no renewal answer -> at expiry ip_valid=0, assigned_ip=0, new dhcp_start; link_up dropped mid-WAIT -> IDLE next cycle.
REQ-044 success and failed rising same cycle in WAIT -> BOUND; lease=0 loaded as 2; lease=FFFFFFFF never decrements.
